// File: rtl/fsm_data_phase.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fsm_data_phase
//  Description : ASCON-128 data-phase controller (AD absorb, domain sep, PT encrypt)
//  Revision    : 1.0
// ============================================================================
module fsm_data_phase #(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] round_i,
    output logic       data_ready_o,
    output logic       en_cpt_perm_o,
    output logic       init_p6_o,
    output logic       input_mode_o,
    output logic       en_reg_state_o,
    output logic       xor_data_o,
    output logic       xor_ext_o,
    output logic       en_cipher_o,
    output logic       end_o
);

    localparam int MAX_BLOCKS = (NB_AD_BLOCKS > NB_PT_BLOCKS) ? NB_AD_BLOCKS : NB_PT_BLOCKS;
    localparam int CNT_W      = $clog2(MAX_BLOCKS) + 1;

    // AD count is checked after its increment, PT count before it.
    localparam logic [CNT_W-1:0] AD_LAST    = CNT_W'(NB_AD_BLOCKS);
    localparam logic [CNT_W-1:0] PT_LAST    = CNT_W'(NB_PT_BLOCKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       LAST_ROUND = 4'd11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AD_WAIT = 3'd1,
        AD_RND  = 3'd2,
        PT_WAIT = 3'd3,
        PT_RND  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        blk_cnt_d      = blk_cnt_q;
        data_ready_o   = 1'b0;
        en_cpt_perm_o  = 1'b0;
        init_p6_o      = 1'b0;
        input_mode_o   = 1'b0;
        en_reg_state_o = 1'b0;
        xor_data_o     = 1'b0;
        xor_ext_o      = 1'b0;
        en_cipher_o    = 1'b0;
        end_o          = 1'b0;

        case (state_q)
            IDLE: begin
                blk_cnt_d = '0;
                if (start_i) begin
                    state_d = AD_WAIT;
                end
            end

            AD_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    xor_data_o     = 1'b1;
                    en_reg_state_o = 1'b1;
                    en_cpt_perm_o  = 1'b1;
                    init_p6_o      = 1'b1;
                    blk_cnt_d      = blk_cnt_q + CNT_ONE;
                    state_d        = AD_RND;
                end
            end

            AD_RND: begin
                en_cpt_perm_o  = 1'b1;
                en_reg_state_o = 1'b1;
                input_mode_o   = 1'b1;
                if (round_i == LAST_ROUND) begin
                    if (blk_cnt_q == AD_LAST) begin
                        xor_ext_o = 1'b1;
                        blk_cnt_d = '0;
                        state_d   = PT_WAIT;
                    end else begin
                        state_d   = AD_WAIT;
                    end
                end
            end

            PT_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    xor_data_o     = 1'b1;
                    en_reg_state_o = 1'b1;
                    en_cipher_o    = 1'b1;
                    if (blk_cnt_q == PT_LAST) begin
                        state_d = DONE;
                    end else begin
                        // Final block skips p6: finalisation owns the next permutation.
                        en_cpt_perm_o = 1'b1;
                        init_p6_o     = 1'b1;
                        blk_cnt_d     = blk_cnt_q + CNT_ONE;
                        state_d       = PT_RND;
                    end
                end
            end

            PT_RND: begin
                en_cpt_perm_o  = 1'b1;
                en_reg_state_o = 1'b1;
                input_mode_o   = 1'b1;
                if (round_i == LAST_ROUND) begin
                    state_d = PT_WAIT;
                end
            end

            DONE: begin
                end_o   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                blk_cnt_d = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_data_phase.sv
`timescale 1ns/1ps
`default_nettype none
// Bench: two configurations (1 AD/4 PT and 2 AD/1 PT) driven in lockstep, each
// checked every cycle against a phase/block-count model plus directed schedules.
module tb_fsm_data_phase;

    logic       clk = 1'b0;
    logic       rst, start, valid;
    logic [3:0] rnd_a, rnd_b;
    int         errors = 0;
    int         checks = 0;
    int         cyc;

    always #5 clk = ~clk;

    logic a_rdy, a_cpt, a_ini, a_mode, a_reg, a_xd, a_xe, a_ci, a_end;
    logic b_rdy, b_cpt, b_ini, b_mode, b_reg, b_xd, b_xe, b_ci, b_end;
    wire [8:0] obs_a = {a_rdy, a_cpt, a_ini, a_mode, a_reg, a_xd, a_xe, a_ci, a_end};
    wire [8:0] obs_b = {b_rdy, b_cpt, b_ini, b_mode, b_reg, b_xd, b_xe, b_ci, b_end};

    fsm_data_phase #(.NB_AD_BLOCKS(1), .NB_PT_BLOCKS(4)) u_a (
        .clock_i(clk), .reset_i(rst), .start_i(start), .data_valid_i(valid),
        .round_i(rnd_a), .data_ready_o(a_rdy), .en_cpt_perm_o(a_cpt),
        .init_p6_o(a_ini), .input_mode_o(a_mode), .en_reg_state_o(a_reg),
        .xor_data_o(a_xd), .xor_ext_o(a_xe), .en_cipher_o(a_ci), .end_o(a_end)
    );

    fsm_data_phase #(.NB_AD_BLOCKS(2), .NB_PT_BLOCKS(1)) u_b (
        .clock_i(clk), .reset_i(rst), .start_i(start), .data_valid_i(valid),
        .round_i(rnd_b), .data_ready_o(b_rdy), .en_cpt_perm_o(b_cpt),
        .init_p6_o(b_ini), .input_mode_o(b_mode), .en_reg_state_o(b_reg),
        .xor_data_o(b_xd), .xor_ext_o(b_xe), .en_cipher_o(b_ci), .end_o(b_end)
    );

    // Shared round counters as seen by each controller.
    always @(posedge clk) begin
        if (rst)        rnd_a <= 4'd0;
        else if (a_cpt) rnd_a <= a_ini ? 4'd6 : rnd_a + 4'd1;
        if (rst)        rnd_b <= 4'd0;
        else if (b_cpt) rnd_b <= b_ini ? 4'd6 : rnd_b + 4'd1;
    end

    // Reference model: phase (idle/wait/rounds/done), AD-vs-PT, blocks taken.
    localparam int P_IDLE = 0, P_WAIT = 1, P_RND = 2, P_DONE = 3;
    int n_ad [2] = '{1, 2};
    int n_pt [2] = '{4, 1};
    int m_ph [2] = '{0, 0};
    int m_ad [2] = '{1, 1};
    int m_blk[2] = '{0, 0};

    logic [63:0] m_acc[2], m_ext[2], m_end[2], m_ini[2], m_ci[2];
    logic [63:0] m_rnd[2], m_r6[2], m_r11[2], m_any[2];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_step(input int d, input logic r, input logic s, input logic v,
                              input logic [3:0] rd, output logic [8:0] e);
        logic rdy, cpt, ini, mode, rg, xd, xe, ci, en;
        int nph, nad, nblk;
        {rdy, cpt, ini, mode, rg, xd, xe, ci, en} = 9'd0;
        nph = m_ph[d]; nad = m_ad[d]; nblk = m_blk[d];
        case (m_ph[d])
            P_IDLE: if (s) begin nph = P_WAIT; nad = 1; nblk = 0; end
            P_WAIT: begin
                rdy = 1'b1;
                if (v) begin
                    xd = 1'b1; rg = 1'b1;
                    if (m_ad[d] == 0) ci = 1'b1;
                    if (m_ad[d] == 0 && m_blk[d] + 1 == n_pt[d]) begin
                        nph = P_DONE;
                    end else begin
                        cpt = 1'b1; ini = 1'b1; nph = P_RND; nblk = m_blk[d] + 1;
                    end
                end
            end
            P_RND: begin
                cpt = 1'b1; rg = 1'b1; mode = 1'b1;
                if (rd == 4'd11) begin
                    nph = P_WAIT;
                    if (m_ad[d] == 1 && m_blk[d] == n_ad[d]) begin
                        xe = 1'b1; nad = 0; nblk = 0;
                    end
                end
            end
            default: begin en = 1'b1; nph = P_IDLE; end
        endcase
        if (r) begin nph = P_IDLE; nblk = 0; end
        m_ph[d] = nph; m_ad[d] = nad; m_blk[d] = nblk;
        e = {rdy, cpt, ini, mode, rg, xd, xe, ci, en};
    endtask

    task automatic tick(input logic r, input logic s, input logic v);
        logic [8:0] ea, eb, o;
        logic [3:0] rr;
        rst = r; start = s; valid = v;
        #1;
        model_step(0, r, s, v, rnd_a, ea);
        model_step(1, r, s, v, rnd_b, eb);
        chk("outputs_cfgA", 64'(obs_a), 64'(ea));
        chk("outputs_cfgB", 64'(obs_b), 64'(eb));
        if (cyc >= 0 && cyc < 64) begin
            for (int d = 0; d < 2; d++) begin
                o  = (d == 0) ? obs_a : obs_b;
                rr = (d == 0) ? rnd_a : rnd_b;
                m_acc[d][cyc] = o[8] & v;
                m_ext[d][cyc] = o[2];
                m_end[d][cyc] = o[0];
                m_ini[d][cyc] = o[6];
                m_ci[d][cyc]  = o[1];
                m_rnd[d][cyc] = o[7] & ~o[6];
                m_r6[d][cyc]  = o[7] & ~o[6] & (rr == 4'd6);
                m_r11[d][cyc] = o[7] & ~o[6] & (rr == 4'd11);
                m_any[d][cyc] = |o;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int sc, input int n);
        logic r, s, v;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = '0; m_ext[d] = '0; m_end[d] = '0; m_ini[d] = '0; m_ci[d] = '0;
            m_rnd[d] = '0; m_r6[d] = '0; m_r11[d] = '0; m_any[d] = '0;
        end
        cyc = 0;
        for (int c = 0; c < n; c++) begin
            r = 1'b0; s = (c == 0); v = 1'b1;
            case (sc)
                2: v = !(c >= 15 && c <= 17);
                4: begin s = (c == 0 || c == 15); r = (c == 12); end
                6: begin
                    s = (c == 0 || c == 3 || c == 5 || c == 10);
                    v = (c == 1 || c == 8 || c == 15 || c == 22 || c == 29) ? 1'b1
                        : 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            tick(r, s, v);
        end
        cyc = -1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] B(input int n);
        return 64'd1 << n;
    endfunction

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m |= B(i);
        return m;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; cyc = -1;
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        #1;
        chk("reset_cfgA", 64'(obs_a), 64'd0);
        chk("reset_cfgB", 64'(obs_b), 64'd0);

        // Nominal run, valid held high.
        run(1, 36);
        chk("s1_acceptA", m_acc[0], B(1) | B(8) | B(15) | B(22) | B(29));
        chk("s1_extA",    m_ext[0], B(7));
        chk("s1_endA",    m_end[0], B(30));
        chk("s1_initA",   m_ini[0], B(1) | B(8) | B(15) | B(22));
        chk("s1_cipherA", m_ci[0],  B(8) | B(15) | B(22) | B(29));
        chk("s1_roundsA", m_rnd[0], rng(2, 7) | rng(9, 14) | rng(16, 21) | rng(23, 28));
        chk("s1_round6A", m_r6[0],  B(2) | B(9) | B(16) | B(23));
        chk("s1_round11A", m_r11[0], B(7) | B(14) | B(21) | B(28));
        chk("s5_acceptB", m_acc[1], B(1) | B(8) | B(15));
        chk("s5_extB",    m_ext[1], B(14));
        chk("s5_initB",   m_ini[1], B(1) | B(8));
        chk("s5_cipherB", m_ci[1],  B(15));
        chk("s5_endB",    m_end[1], B(16));

        // Valid gap before the second PT block.
        run(2, 40);
        chk("s2_acceptA", m_acc[0], B(1) | B(8) | B(18) | B(25) | B(32));
        chk("s2_endA",    m_end[0], B(33));
        chk("s2_endB",    m_end[1], B(19));

        // Reset inside the round phase, then restart.
        run(4, 31);
        chk("s4_quietA",  m_any[0] & rng(13, 15), 64'd0);
        chk("s4_quietB",  m_any[1] & rng(13, 15), 64'd0);
        chk("s4_acceptA", m_acc[0], B(1) | B(8) | B(16) | B(23) | B(30));
        chk("s4_extA",    m_ext[0], B(7) | B(22));
        chk("s4_extB",    m_ext[1], B(29));

        // Stray start pulses and valid toggling during rounds.
        run(6, 36);
        chk("s6_acceptA", m_acc[0], B(1) | B(8) | B(15) | B(22) | B(29));
        chk("s6_extA",    m_ext[0], B(7));
        chk("s6_endA",    m_end[0], B(30));
        chk("s6_extB",    m_ext[1], B(14));
        chk("s6_endB",    m_end[1], B(16));

        // Random traffic with occasional resets, model-checked every cycle.
        cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
